// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared opcodes, function codes, control enums and memory map for
//           the single-cycle MIPS-subset CPU. CPU_EXT_ALU_EN adds the extended
//           ALU encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int MEM_WORDS      = 4096;
  localparam int DATA_BASE_WORD = 2048;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

`ifdef CPU_EXT_ALU_EN
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
`endif

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLT,
    ALU_XOR,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RT,
    DST_RD,
    DST_R31
  } wb_dst_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_src_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_mem_if.sv
// ============================================================================
// Module  : cpu_mem_if
// Purpose : Instruction-fetch and data-access bus between the CPU core and
//           its unified word-addressed memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_mem_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] iaddr;
  logic [31:0]       idata;
  logic [ADDR_W-1:0] daddr;
  logic [31:0]       wdata;
  logic              we;
  logic [31:0]       rdata;

  modport master (
    output iaddr, daddr, wdata, we,
    input  idata, rdata
  );

  modport slave (
    input  iaddr, daddr, wdata, we,
    output idata, rdata
  );
endinterface

`default_nettype wire

// File: rtl/cpu_memory.sv
// ============================================================================
// Module  : cpu_memory
// Purpose : Unified 32-bit word memory with a combinational fetch port, a
//           combinational data read port and a clocked write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_memory #(
  parameter int MEM_WORDS = 4096
) (
  input logic       clk,
  cpu_mem_if.slave  bus
);

  // No reset: the preloaded program and data image must survive reset.
  logic [31:0] mem [0:MEM_WORDS-1];

  assign bus.idata = mem[bus.iaddr];
  assign bus.rdata = mem[bus.daddr];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.daddr] <= bus.wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module  : cpu_regfile
// Purpose : 32 x 32-bit register file, two asynchronous read ports, one
//           synchronous write port; register 0 is hard-wired to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [0:31];

  logic [31:0] reg0,  reg1,  reg2,  reg3,  reg4,  reg5,  reg6,  reg7;
  logic [31:0] reg8,  reg9,  reg10, reg11, reg12, reg13, reg14, reg15;
  logic [31:0] reg16, reg17, reg18, reg19, reg20, reg21, reg22, reg23;
  logic [31:0] reg24, reg25, reg26, reg27, reg28, reg29, reg30, reg31;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Named per-register views; reg0 is a constant so it reads zero regardless.
  assign reg0  = '0;         assign reg1  = regs_q[1];
  assign reg2  = regs_q[2];  assign reg3  = regs_q[3];
  assign reg4  = regs_q[4];  assign reg5  = regs_q[5];
  assign reg6  = regs_q[6];  assign reg7  = regs_q[7];
  assign reg8  = regs_q[8];  assign reg9  = regs_q[9];
  assign reg10 = regs_q[10]; assign reg11 = regs_q[11];
  assign reg12 = regs_q[12]; assign reg13 = regs_q[13];
  assign reg14 = regs_q[14]; assign reg15 = regs_q[15];
  assign reg16 = regs_q[16]; assign reg17 = regs_q[17];
  assign reg18 = regs_q[18]; assign reg19 = regs_q[19];
  assign reg20 = regs_q[20]; assign reg21 = regs_q[21];
  assign reg22 = regs_q[22]; assign reg23 = regs_q[23];
  assign reg24 = regs_q[24]; assign reg25 = regs_q[25];
  assign reg26 = regs_q[26]; assign reg27 = regs_q[27];
  assign reg28 = regs_q[28]; assign reg29 = regs_q[29];
  assign reg30 = regs_q[30]; assign reg31 = regs_q[31];

  logic [31:0] rd_view [0:31];

  assign rd_view = '{reg0,  reg1,  reg2,  reg3,  reg4,  reg5,  reg6,  reg7,
                     reg8,  reg9,  reg10, reg11, reg12, reg13, reg14, reg15,
                     reg16, reg17, reg18, reg19, reg20, reg21, reg22, reg23,
                     reg24, reg25, reg26, reg27, reg28, reg29, reg30, reg31};

  assign rdata1_o = rd_view[raddr1_i];
  assign rdata2_o = rd_view[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/single_cycle_cpu.sv
// ============================================================================
// Module  : single_cycle_cpu
// Purpose : Single-cycle 32-bit MIPS-subset processor with unified memory.
//           Define CPU_EXT_ALU_EN to add AND/OR/NOR/SLL/SRL/ANDI/ORI/SLTI.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int          MEM_WORDS      = cpu_pkg::MEM_WORDS,
  parameter int          DATA_BASE_WORD = cpu_pkg::DATA_BASE_WORD,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  if (DATA_BASE_WORD >= MEM_WORDS) begin : g_bad_data_base
    $error("DATA_BASE_WORD must lie inside the memory");
  end

  logic [31:0] PC;
  logic [31:0] pc_d;
  logic [31:0] instruction;

  cpu_mem_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_memory #(.MEM_WORDS(MEM_WORDS)) MEMORY (
    .clk (clk),
    .bus (bus)
  );

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  assign bus.iaddr   = PC[ADDR_W+1:2];
  assign instruction = bus.idata;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];
  assign target = instruction[25:0];

`ifdef CPU_EXT_ALU_EN
  logic [4:0] shamt;
  assign shamt = instruction[10:6];
`endif

  logic    reg_write;
  wb_dst_e wb_dst;
  wb_src_e wb_src;
  alu_op_e alu_op;
  logic    alu_src_imm;
  logic    imm_zext;
  logic    mem_write;
  logic    branch_eq;
  logic    branch_ne;
  logic    jump;
  logic    jump_reg;

  // Anything not matched below falls through the defaults and retires as NOP.
  always_comb begin
    reg_write   = 1'b0;
    wb_dst      = DST_RT;
    wb_src      = WB_ALU;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    mem_write   = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    jump_reg    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_ADD; end
          FN_SUB: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_SUB; end
          FN_SLT: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_SLT; end
          FN_JR:  jump_reg = 1'b1;
`ifdef CPU_EXT_ALU_EN
          FN_AND: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_AND; end
          FN_OR:  begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_OR;  end
          FN_NOR: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_NOR; end
          FN_SLL: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_SLL; end
          FN_SRL: begin reg_write = 1'b1; wb_dst = DST_RD; alu_op = ALU_SRL; end
`endif
          default: ;
        endcase
      end
      OP_ADDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_XORI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_XOR;
      end
`ifdef CPU_EXT_ALU_EN
      OP_SLTI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = ALU_SLT;
      end
      OP_ANDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_AND;
      end
      OP_ORI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_OR;
      end
`endif
      OP_LW: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        wb_src      = WB_MEM;
      end
      OP_SW: begin
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_BEQ: branch_eq = 1'b1;
      OP_BNE: branch_ne = 1'b1;
      OP_J:   jump = 1'b1;
      OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        wb_dst    = DST_R31;
        wb_src    = WB_PC4;
      end
      default: ;
    endcase
  end

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  cpu_regfile regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_data),
    .rdata2_o (rt_data),
    .we_i     (reg_write & ~reset),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data)
  );

  logic [31:0] imm_sext;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  assign imm_sext = sext16(imm);
  assign imm_ext  = imm_zext ? {16'h0000, imm} : imm_sext;
  assign alu_b    = alu_src_imm ? imm_ext : rt_data;

  always_comb begin
    alu_result = rs_data + alu_b;
    case (alu_op)
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_SLT: alu_result = {31'b0, $signed(rs_data) < $signed(alu_b)};
      ALU_XOR: alu_result = rs_data ^ alu_b;
`ifdef CPU_EXT_ALU_EN
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_NOR: alu_result = ~(rs_data | alu_b);
      ALU_SLL: alu_result = rt_data << shamt;
      ALU_SRL: alu_result = rt_data >> shamt;
`endif
      default: ;
    endcase
  end

  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_we;
  logic [31:0]       dmem_rdata;

  // Low address bits are dropped: only aligned word accesses exist.
  assign dmem_addr  = alu_result[ADDR_W+1:2];
  assign dmem_wdata = rt_data;
  assign dmem_we    = mem_write & ~reset;
  assign bus.daddr  = dmem_addr;
  assign bus.wdata  = dmem_wdata;
  assign bus.we     = dmem_we;
  assign dmem_rdata = bus.rdata;

  logic [31:0] pc_plus4;
  assign pc_plus4 = PC + 32'd4;

  always_comb begin
    case (wb_dst)
      DST_RD:  wb_addr = rd;
      DST_R31: wb_addr = 5'd31;
      default: wb_addr = rt;
    endcase
  end

  always_comb begin
    case (wb_src)
      WB_MEM:  wb_data = dmem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  logic branch_taken;
  assign branch_taken = (branch_eq & (rs_data == rt_data)) |
                        (branch_ne & (rs_data != rt_data));

  always_comb begin
    pc_d = pc_plus4;
    if (jump_reg) begin
      pc_d = rs_data;
    end else if (jump) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end else if (branch_taken) begin
      pc_d = pc_plus4 + (imm_sext << 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= RESET_PC;
    end else begin
      PC <= pc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_single_cycle_cpu.sv
// ============================================================================
// Module  : tb_single_cycle_cpu
// Purpose : Directed self-checking bench for single_cycle_cpu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_single_cycle_cpu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [31:0] prog [0:15];

  always #5 clk = ~clk;

  single_cycle_cpu dut (
    .clk   (clk),
    .reset (reset)
  );

  cpu_mem_if #(.ADDR_W(12)) mon ();
  assign mon.iaddr = dut.PC[13:2];
  assign mon.idata = dut.instruction;
  assign mon.daddr = dut.dmem_addr;
  assign mon.wdata = dut.dmem_wdata;
  assign mon.we    = dut.dmem_we;
  assign mon.rdata = dut.dmem_rdata;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] get_reg(input int n);
    case (n)
      0:  return dut.regfile.reg0;   1:  return dut.regfile.reg1;
      2:  return dut.regfile.reg2;   3:  return dut.regfile.reg3;
      4:  return dut.regfile.reg4;   5:  return dut.regfile.reg5;
      6:  return dut.regfile.reg6;   7:  return dut.regfile.reg7;
      8:  return dut.regfile.reg8;   9:  return dut.regfile.reg9;
      10: return dut.regfile.reg10;  11: return dut.regfile.reg11;
      12: return dut.regfile.reg12;  13: return dut.regfile.reg13;
      14: return dut.regfile.reg14;  15: return dut.regfile.reg15;
      16: return dut.regfile.reg16;  17: return dut.regfile.reg17;
      18: return dut.regfile.reg18;  19: return dut.regfile.reg19;
      20: return dut.regfile.reg20;  21: return dut.regfile.reg21;
      22: return dut.regfile.reg22;  23: return dut.regfile.reg23;
      24: return dut.regfile.reg24;  25: return dut.regfile.reg25;
      26: return dut.regfile.reg26;  27: return dut.regfile.reg27;
      28: return dut.regfile.reg28;  29: return dut.regfile.reg29;
      30: return dut.regfile.reg30;  31: return dut.regfile.reg31;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic load_prog(input int n);
    for (int i = 0; i < 64; i++) dut.MEMORY.mem[i] = 32'h0;
    dut.MEMORY.mem[2048] = 32'h0;
    for (int i = 0; i < n; i++) dut.MEMORY.mem[i] = prog[i];
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    prog[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd17, 16'd6);
    prog[2] = enc_i(6'h08, 5'd0, 5'd18, 16'd7);
    load_prog(3);
    pulse_reset();
    step(3);
    pulse_reset();
    n_checks++;
    if (dut.PC !== 32'h0) begin
      n_fails++; $display("FAIL reset_pc: got %h expected %h", dut.PC, 32'h0);
    end
    for (int r = 0; r < 32; r++) begin
      n_checks++;
      if (get_reg(r) !== 32'h0) begin
        n_fails++; $display("FAIL reset_reg%0d: got %h expected %h", r, get_reg(r), 32'h0);
      end
    end
    n_checks++;
    if (mon.idata !== prog[0]) begin
      n_fails++; $display("FAIL reset_fetch: got %h expected %h", mon.idata, prog[0]);
    end
    step(1);
    n_checks++;
    if (dut.PC !== 32'd4) begin
      n_fails++; $display("FAIL seq_pc4: got %h expected %h", dut.PC, 32'd4);
    end
    n_checks++;
    if (get_reg(16) !== 32'd5) begin
      n_fails++; $display("FAIL seq_reg16: got %h expected %h", get_reg(16), 32'd5);
    end
    step(1);
    n_checks++;
    if (dut.PC !== 32'd8) begin
      n_fails++; $display("FAIL seq_pc8: got %h expected %h", dut.PC, 32'd8);
    end
  endtask

  task automatic test_arith();
    int          rn [10] = '{16, 17, 18, 19, 20, 21, 22, 23, 24, 25};
    logic [31:0] ev [10] = '{32'd5, 32'd5, 32'd0, 32'd10, 32'd0, 32'd0,
                             32'hFFFF_FFFD, 32'd1, 32'hFFFF_0002, 32'd0};
    prog[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd17, 16'd5);
    prog[2] = enc_r(5'd16, 5'd17, 5'd18, 5'd0, 6'h22);
    prog[3] = enc_r(5'd16, 5'd17, 5'd19, 5'd0, 6'h20);
    prog[4] = enc_r(5'd16, 5'd17, 5'd20, 5'd0, 6'h2A);
    prog[5] = enc_i(6'h0E, 5'd16, 5'd21, 16'd5);
    prog[6] = enc_i(6'h08, 5'd0, 5'd22, 16'hFFFD);
    prog[7] = enc_r(5'd22, 5'd16, 5'd23, 5'd0, 6'h2A);
    prog[8] = enc_i(6'h0E, 5'd22, 5'd24, 16'hFFFF);
    prog[9] = enc_i(6'h08, 5'd22, 5'd25, 16'd3);
    load_prog(10);
    pulse_reset();
    step(10);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (get_reg(rn[i]) !== ev[i]) begin
        n_fails++;
        $display("FAIL arith_reg%0d: got %h expected %h", rn[i], get_reg(rn[i]), ev[i]);
      end
    end
    n_checks++;
    if (dut.PC !== 32'd40) begin
      n_fails++; $display("FAIL arith_pc: got %h expected %h", dut.PC, 32'd40);
    end
  endtask

  task automatic test_jump_link_mem();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd16, 16'd5);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd17, 16'd5);
    prog[2]  = enc_i(6'h08, 5'd0, 5'd18, 16'd0);
    prog[3]  = enc_j(6'h03, 26'd8);
    prog[4]  = enc_i(6'h08, 5'd0, 5'd24, 16'd20);
    prog[5]  = enc_i(6'h2B, 5'd0, 5'd24, 16'h2000);
    prog[6]  = enc_i(6'h23, 5'd0, 5'd25, 16'h2000);
    prog[7]  = enc_j(6'h02, 26'd7);
    prog[8]  = enc_r(5'd18, 5'd16, 5'd18, 5'd0, 6'h20);
    prog[9]  = enc_i(6'h08, 5'd17, 5'd17, 16'hFFFF);
    prog[10] = enc_i(6'h05, 5'd17, 5'd0, 16'hFFFD);
    prog[11] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    load_prog(12);
    pulse_reset();
    step(4);
    n_checks++;
    if (get_reg(31) !== 32'd16) begin
      n_fails++; $display("FAIL jal_link: got %h expected %h", get_reg(31), 32'd16);
    end
    n_checks++;
    if (dut.PC !== 32'd32) begin
      n_fails++; $display("FAIL jal_target: got %h expected %h", dut.PC, 32'd32);
    end
    step(16);
    n_checks++;
    if (dut.PC !== 32'd16) begin
      n_fails++; $display("FAIL jr_return: got %h expected %h", dut.PC, 32'd16);
    end
    n_checks++;
    if (get_reg(18) !== 32'd25) begin
      n_fails++; $display("FAIL sub_reg18: got %h expected %h", get_reg(18), 32'd25);
    end
    step(1);
    n_checks++;
    if (mon.we !== 1'b1 || mon.daddr !== 12'd2048) begin
      n_fails++; $display("FAIL sw_bus: got we=%b addr=%h expected we=1 addr=%h", mon.we, mon.daddr, 12'd2048);
    end
    step(1);
    n_checks++;
    if (dut.MEMORY.mem[2048] !== 32'd20) begin
      n_fails++; $display("FAIL sw_mem: got %h expected %h", dut.MEMORY.mem[2048], 32'd20);
    end
    step(2);
    n_checks++;
    if (get_reg(25) !== 32'd20) begin
      n_fails++; $display("FAIL lw_reg25: got %h expected %h", get_reg(25), 32'd20);
    end
    n_checks++;
    if (dut.PC !== 32'd28) begin
      n_fails++; $display("FAIL j_self: got %h expected %h", dut.PC, 32'd28);
    end
    n_checks++;
    if (get_reg(20) !== 32'd0) begin
      n_fails++; $display("FAIL jl_reg20: got %h expected %h", get_reg(20), 32'd0);
    end
  endtask

  task automatic test_branch();
    prog[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd17, 16'd5);
    prog[2] = enc_i(6'h04, 5'd16, 5'd17, 16'd1);
    prog[3] = enc_i(6'h08, 5'd0, 5'd19, 16'd1);
    prog[4] = enc_i(6'h05, 5'd16, 5'd17, 16'd1);
    prog[5] = enc_i(6'h08, 5'd0, 5'd18, 16'd10);
    prog[6] = enc_r(5'd16, 5'd17, 5'd20, 5'd0, 6'h2A);
    prog[7] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    load_prog(8);
    pulse_reset();
    step(3);
    n_checks++;
    if (dut.PC !== 32'd16) begin
      n_fails++; $display("FAIL beq_taken: got %h expected %h", dut.PC, 32'd16);
    end
    step(1);
    n_checks++;
    if (dut.PC !== 32'd20) begin
      n_fails++; $display("FAIL bne_not_taken: got %h expected %h", dut.PC, 32'd20);
    end
    step(3);
    n_checks++;
    if (dut.PC !== 32'd28) begin
      n_fails++; $display("FAIL beq_backward: got %h expected %h", dut.PC, 32'd28);
    end
    n_checks++;
    if (get_reg(19) !== 32'd0) begin
      n_fails++; $display("FAIL br_reg19: got %h expected %h", get_reg(19), 32'd0);
    end
    n_checks++;
    if (get_reg(18) !== 32'd10) begin
      n_fails++; $display("FAIL br_reg18: got %h expected %h", get_reg(18), 32'd10);
    end
    n_checks++;
    if (get_reg(20) !== 32'd0) begin
      n_fails++; $display("FAIL br_reg20: got %h expected %h", get_reg(20), 32'd0);
    end
  endtask

  task automatic test_zero_unknown();
    prog[0] = enc_i(6'h08, 5'd0, 5'd5, 16'd3);
    prog[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    prog[2] = enc_i(6'h3F, 5'd5, 5'd5, 16'h1234);
    prog[3] = enc_r(5'd5, 5'd5, 5'd9, 5'd0, 6'h3F);
    prog[4] = enc_r(5'd0, 5'd5, 5'd10, 5'd0, 6'h20);
    load_prog(5);
    pulse_reset();
    step(2);
    n_checks++;
    if (get_reg(0) !== 32'd0) begin
      n_fails++; $display("FAIL zero_reg0: got %h expected %h", get_reg(0), 32'd0);
    end
    step(1);
    n_checks++;
    if (dut.PC !== 32'd12 || get_reg(5) !== 32'd3) begin
      n_fails++; $display("FAIL unk_opcode: got pc=%h r5=%h expected pc=%h r5=%h", dut.PC, get_reg(5), 32'd12, 32'd3);
    end
    step(1);
    n_checks++;
    if (dut.PC !== 32'd16 || get_reg(9) !== 32'd0) begin
      n_fails++; $display("FAIL unk_funct: got pc=%h r9=%h expected pc=%h r9=%h", dut.PC, get_reg(9), 32'd16, 32'd0);
    end
    step(1);
    n_checks++;
    if (get_reg(10) !== 32'd3) begin
      n_fails++; $display("FAIL zero_read: got %h expected %h", get_reg(10), 32'd3);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] sw_word;
    sw_word = enc_i(6'h2B, 5'd0, 5'd16, 16'h2000);
    prog[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd17, 16'd6);
    prog[2] = enc_i(6'h08, 5'd0, 5'd18, 16'd7);
    prog[3] = enc_i(6'h08, 5'd0, 5'd19, 16'd8);
    prog[4] = enc_i(6'h08, 5'd0, 5'd20, 16'd9);
    prog[5] = sw_word;
    load_prog(6);
    dut.MEMORY.mem[2048] = 32'hCAFE_F00D;
    pulse_reset();
    step(5);
    n_checks++;
    if (dut.PC !== 32'd20 || get_reg(20) !== 32'd9) begin
      n_fails++; $display("FAIL mid_pre: got pc=%h r20=%h expected pc=%h r20=%h", dut.PC, get_reg(20), 32'd20, 32'd9);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mon.we !== 1'b0) begin
      n_fails++; $display("FAIL mid_we_gated: got %b expected %b", mon.we, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (dut.PC !== 32'h0) begin
      n_fails++; $display("FAIL mid_pc: got %h expected %h", dut.PC, 32'h0);
    end
    for (int r = 16; r <= 20; r++) begin
      n_checks++;
      if (get_reg(r) !== 32'h0) begin
        n_fails++; $display("FAIL mid_reg%0d: got %h expected %h", r, get_reg(r), 32'h0);
      end
    end
    n_checks++;
    if (dut.MEMORY.mem[2048] !== 32'hCAFE_F00D) begin
      n_fails++; $display("FAIL mid_data: got %h expected %h", dut.MEMORY.mem[2048], 32'hCAFE_F00D);
    end
    n_checks++;
    if (dut.MEMORY.mem[5] !== sw_word) begin
      n_fails++; $display("FAIL mid_text: got %h expected %h", dut.MEMORY.mem[5], sw_word);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arith();
    test_jump_link_mem();
    test_branch();
    test_zero_unknown();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
